gate_actuator: RTL and testbench

Downstream of the parking controller. Converts one gate-open request level (entrance or exit gate output) into motor drive for a single barrier arm. Handles limit switches, hold-open time, obstruction reversal and travel-timeout fault. One instance per gate.

---
 rtl/gate_pkg.sv | 18 +
 rtl/gate_actuator.sv | 106 ++++++++++
 tb/tb_gate_actuator.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// Shared constants and state encoding for the barrier-arm gate actuator.
package gate_pkg;

  localparam int unsigned DEF_CNT_W          = 16;
  localparam logic [15:0] DEF_TRAVEL_TIMEOUT = 16'd5000;
  localparam logic [15:0] DEF_HOLD_TIME      = 16'd2000;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    CLOSING = 3'd3,
    FAULT   = 3'd4
  } state_t;

endpackage

// File: rtl/gate_actuator.sv
// Barrier-arm motor controller: turns an open-request level into up/down drive,
// with limit switches, hold-open time, obstruction reversal and travel timeout.
module gate_actuator
  import gate_pkg::*;
#(
  parameter int unsigned      CNT_W          = DEF_CNT_W,
  parameter logic [CNT_W-1:0] TRAVEL_TIMEOUT = CNT_W'(DEF_TRAVEL_TIMEOUT),
  parameter logic [CNT_W-1:0] HOLD_TIME      = CNT_W'(DEF_HOLD_TIME)
) (
  input  logic clock,
  input  logic reset,
  input  logic open_req,
  input  logic limit_open,
  input  logic limit_closed,
  input  logic obstruction,
  input  logic fault_clear,
  output logic motor_up,
  output logic motor_down,
  output logic gate_is_open,
  output logic fault
);

  // Last timer values before a timeout / hold expiry fires.
  localparam logic [CNT_W-1:0] TRAVEL_LAST = TRAVEL_TIMEOUT - CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = HOLD_TIME - CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_next;
  logic             both_limits;
  logic             hold_req;

  assign both_limits = limit_open && limit_closed;
  assign hold_req    = open_req || obstruction;

  // Next-state selection; sensor conflict wins in every non-fault state.
  always_comb begin
    state_next = state;
    unique case (state)
      CLOSED: begin
        if (both_limits)        state_next = FAULT;
        else if (open_req)      state_next = OPENING;
        else if (!limit_closed) state_next = CLOSING;
      end
      OPENING: begin
        if (both_limits)                state_next = FAULT;
        else if (limit_open)            state_next = OPEN;
        else if (timer == TRAVEL_LAST)  state_next = FAULT;
      end
      OPEN: begin
        if (both_limits)                         state_next = FAULT;
        else if (!hold_req && timer == HOLD_LAST) state_next = CLOSING;
      end
      CLOSING: begin
        if (both_limits)               state_next = FAULT;
        else if (hold_req)             state_next = OPENING;
        else if (limit_closed)         state_next = CLOSED;
        else if (timer == TRAVEL_LAST) state_next = FAULT;
      end
      FAULT: begin
        if (fault_clear && !both_limits) state_next = CLOSING;
      end
      default: state_next = CLOSED;
    endcase
  end

  // Shared timer: clears on state change, held at zero while the open hold is requested.
  always_comb begin
    timer_next = timer;
    if (state_next != state) begin
      timer_next = '0;
    end else if (state == OPEN && hold_req) begin
      timer_next = '0;
    end else if (timer != '1) begin
      timer_next = timer + CNT_W'(1);
    end
  end

  // State and timer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CLOSED;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // Outputs registered from the next state so they always mirror the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      motor_up     <= 1'b0;
      motor_down   <= 1'b0;
      gate_is_open <= 1'b0;
      fault        <= 1'b0;
    end else begin
      motor_up     <= (state_next == OPENING);
      motor_down   <= (state_next == CLOSING);
      gate_is_open <= (state_next == OPEN);
      fault        <= (state_next == FAULT);
    end
  end

endmodule

// File: tb/tb_gate_actuator.sv
// Directed bench for gate_actuator with a phase/counter reference model.
module tb_gate_actuator;

  localparam int TT = 20;
  localparam int HT = 10;

  localparam int P_DOWN  = 0;
  localparam int P_RISE  = 1;
  localparam int P_UP    = 2;
  localparam int P_LOWER = 3;
  localparam int P_ERR   = 4;

  logic clock        = 1'b0;
  logic reset        = 1'b0;
  logic open_req     = 1'b0;
  logic limit_open   = 1'b0;
  logic limit_closed = 1'b1;
  logic obstruction  = 1'b0;
  logic fault_clear  = 1'b0;
  logic motor_up, motor_down, gate_is_open, fault;

  int checks  = 0;
  int errors  = 0;
  bit started = 1'b0;

  // Reference model: phase, cycles spent in the phase, consecutive quiet samples while up.
  int ph     = P_DOWN;
  int tcount = 0;
  int quiet  = 0;
  int nph;
  int nq;
  logic both;

  gate_actuator #(
    .CNT_W         (16),
    .TRAVEL_TIMEOUT(16'd20),
    .HOLD_TIME     (16'd10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .open_req    (open_req),
    .limit_open  (limit_open),
    .limit_closed(limit_closed),
    .obstruction (obstruction),
    .fault_clear (fault_clear),
    .motor_up    (motor_up),
    .motor_down  (motor_down),
    .gate_is_open(gate_is_open),
    .fault       (fault)
  );

  always #5 clock = ~clock;

  // Model: what the arm should do next given the current phase and sensors.
  always_comb begin
    both = limit_open && limit_closed;
    nph  = ph;
    nq   = 0;
    case (ph)
      P_DOWN: begin
        if (both) nph = P_ERR;
        else if (open_req) nph = P_RISE;
        else if (!limit_closed) nph = P_LOWER;
      end
      P_RISE: begin
        if (both) nph = P_ERR;
        else if (limit_open) nph = P_UP;
        else if (tcount + 1 >= TT) nph = P_ERR;
      end
      P_UP: begin
        if (both) nph = P_ERR;
        else if (open_req || obstruction) nq = 0;
        else begin
          nq = quiet + 1;
          if (nq >= HT) nph = P_LOWER;
        end
      end
      P_LOWER: begin
        if (both) nph = P_ERR;
        else if (obstruction || open_req) nph = P_RISE;
        else if (limit_closed) nph = P_DOWN;
        else if (tcount + 1 >= TT) nph = P_ERR;
      end
      default: begin
        if (fault_clear && !both) nph = P_LOWER;
      end
    endcase
  end

  // Model state update.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ph     <= P_DOWN;
      tcount <= 0;
      quiet  <= 0;
    end else begin
      ph <= nph;
      if (nph != ph) begin
        tcount <= 0;
        quiet  <= 0;
      end else begin
        tcount <= tcount + 1;
        quiet  <= nq;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (started) begin
      logic [3:0] want;
      logic [3:0] got;
      want = {ph == P_RISE, ph == P_LOWER, ph == P_UP, ph == P_ERR};
      got  = {motor_up, motor_down, gate_is_open, fault};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL model_cmp t=%0t got %b want %b (up,down,open,fault)", $time, got, want);
      end
    end
  end

  task automatic chk(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %b want %b", name, $time, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_up"},    motor_up,     1'b0);
    chk({name, "_down"},  motor_down,   1'b0);
    chk({name, "_open"},  gate_is_open, 1'b0);
    chk({name, "_fault"}, fault,        1'b0);
  endtask

  initial begin
    #1 reset = 1'b1;
    tick(2);
    started = 1'b1;
    chk_idle("reset");
    reset = 1'b0;
    tick(1);
    chk_idle("closed_idle");

    // Normal cycle (cycle 0 = request raised).
    open_req = 1'b1;
    tick(1);
    limit_closed = 1'b0;
    chk("t1_up_c1", motor_up, 1'b1);
    tick(4);
    chk("t1_up_c5", motor_up, 1'b1);
    limit_open = 1'b1;
    tick(1);
    chk("t1_open_c6", gate_is_open, 1'b1);
    chk("t1_upoff_c6", motor_up, 1'b0);
    chk("t1_model_up", logic'(ph == P_UP), 1'b1);
    tick(2);
    open_req = 1'b0;
    tick(9);
    chk("t1_open_c17", gate_is_open, 1'b1);
    chk("t1_nodown_c17", motor_down, 1'b0);
    tick(1);
    chk("t1_down_c18", motor_down, 1'b1);
    limit_open = 1'b0;
    tick(3);
    limit_closed = 1'b1;
    tick(1);
    chk_idle("t1_closed");

    // Obstruction reversal with simultaneous closed limit.
    limit_closed = 1'b0;
    tick(1);
    chk("t2_down", motor_down, 1'b1);
    obstruction  = 1'b1;
    limit_closed = 1'b1;
    tick(1);
    chk("t2_rev_up", motor_up, 1'b1);
    chk("t2_rev_down", motor_down, 1'b0);
    obstruction  = 1'b0;
    limit_closed = 1'b0;
    tick(2);
    limit_open = 1'b1;
    tick(1);
    chk("t3_open_o", gate_is_open, 1'b1);

    // Hold extension: obstruction at hold-timer 7.
    tick(7);
    obstruction = 1'b1;
    tick(1);
    obstruction = 1'b0;
    chk("t3_open_o8", gate_is_open, 1'b1);
    tick(9);
    chk("t3_open_o17", gate_is_open, 1'b1);
    tick(1);
    chk("t3_down_o18", motor_down, 1'b1);
    limit_open   = 1'b0;
    limit_closed = 1'b1;
    tick(1);
    chk_idle("t3_closed");

    // Travel timeout while opening.
    open_req = 1'b1;
    tick(1);
    limit_closed = 1'b0;
    tick(19);
    chk("t4_up_c20", motor_up, 1'b1);
    tick(1);
    chk("t4_fault_c21", fault, 1'b1);
    chk("t4_up_off", motor_up, 1'b0);
    chk("t4_down_off", motor_down, 1'b0);
    chk("t4_model_err", logic'(ph == P_ERR), 1'b1);
    open_req = 1'b0;
    tick(1);
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    chk("t4_clear_down", motor_down, 1'b1);
    chk("t4_clear_fault", fault, 1'b0);
    limit_closed = 1'b1;
    tick(1);
    chk_idle("t4_closed");

    // Sensor error in OPEN; clear refused while both limits stay active.
    open_req = 1'b1;
    tick(1);
    limit_closed = 1'b0;
    tick(1);
    limit_open = 1'b1;
    tick(1);
    chk("t5_open", gate_is_open, 1'b1);
    limit_closed = 1'b1;
    tick(1);
    chk("t5_fault", fault, 1'b1);
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    chk("t5_stay_fault", fault, 1'b1);
    tick(1);
    chk("t5_stay_fault2", fault, 1'b1);
    limit_closed = 1'b0;
    open_req     = 1'b0;
    fault_clear  = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    chk("t5_clear_down", motor_down, 1'b1);
    limit_open   = 1'b0;
    limit_closed = 1'b1;
    tick(1);
    chk_idle("t5_closed");

    // Asynchronous reset mid-opening, then closed-limit recovery.
    open_req = 1'b1;
    tick(1);
    limit_closed = 1'b0;
    chk("t6_up", motor_up, 1'b1);
    tick(3);
    #2 reset = 1'b1;
    #1;
    chk_idle("t6_async");
    open_req = 1'b0;
    tick(1);
    reset = 1'b0;
    chk("t6_rel_down", motor_down, 1'b0);
    tick(2);
    chk("t6_recover_down", motor_down, 1'b1);
    limit_closed = 1'b1;
    tick(2);
    chk_idle("t6_closed");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
